jtframe_dual_ram_rdstream: RTL and testbench

JTFRAME_DUAL_RAM_RDSTREAM -- requirements
Module: jtframe_dual_ram_rdstream

---
 rtl/jtframe_rdstream_pkg.sv | 13 +
 rtl/jtframe_rdstream_fifo.sv | 45 ++++
 rtl/jtframe_dual_ram_rdstream.sv | 92 +++++++++
 tb/tb_jtframe_dual_ram_rdstream.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_rdstream_pkg.sv
// Shared types for the dual-port RAM read streamer.
// Holds the FSM encoding and the depth of the output skid FIFO.
package jtframe_rdstream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/jtframe_rdstream_fifo.sv
// Two-entry FIFO holding words returned from the RAM; latency 1 cycle write-to-head.
// Writes are dropped when full and no read is happening; the head is exposed combinationally.
module jtframe_rdstream_fifo
  import jtframe_rdstream_pkg::*;
#(
  parameter int w = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [w-1:0] din,
  input  logic         rd,
  output logic [w-1:0] dout,
  output logic         vld,
  output logic [1:0]   cnt
);

  logic [w-1:0] mem0, mem1;
  logic         wptr, rptr;
  logic         do_wr, do_rd;

  assign vld   = (cnt != 2'd0);
  assign do_rd = rd & vld;
  assign do_wr = wr & ((cnt != FIFO_DEPTH) | do_rd);
  assign dout  = rptr ? mem1 : mem0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0 <= '0;
      mem1 <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (do_wr) begin
        if (wptr) mem1 <= din;
        else      mem0 <= din;
        wptr <= ~wptr;
      end
      if (do_rd) rptr <= ~rptr;
      cnt <= cnt + {1'b0, do_wr} - {1'b0, do_rd};
    end
  end

endmodule

// File: rtl/jtframe_dual_ram_rdstream.sv
// Streams len words from a synchronous dual-port RAM starting at base; first word 2 cycles after start.
// Reads issue only while FIFO room remains (counting the read in flight), so dout_ready stalls hold data.
module jtframe_dual_ram_rdstream
  import jtframe_rdstream_pkg::*;
#(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [aw-1:0] base,
  input  logic [aw:0]   len,
  output logic          busy,
  output logic          done,
  output logic [aw-1:0] ram_addr,
  input  logic [dw-1:0] ram_q,
  output logic [dw-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last
);

  localparam logic [aw:0] ONE = {{aw{1'b0}}, 1'b1};

  state_t       state, state_nx;
  logic [aw:0]  cnt;
  logic         inflight, inflight_last;
  logic         start_ok, issue, pop, last_issue;
  logic [1:0]   fifo_cnt, occ_eff;
  logic [dw:0]  fifo_q;

  assign busy       = (state != IDLE);
  assign start_ok   = (state == IDLE) & start;
  assign pop        = dout_valid & dout_ready;
  // A word leaving this cycle frees its slot, which keeps 1 word/cycle flowing
  assign occ_eff    = fifo_cnt - {1'b0, pop};
  assign issue      = (state == READ) && ((occ_eff + {1'b0, inflight}) < FIFO_DEPTH);
  assign last_issue = issue && (cnt == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && len != '0) state_nx = READ;
      READ:    if (last_issue) state_nx = DRAIN;
      DRAIN:   if (pop && dout_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr      <= '0;
      cnt           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (start_ok) begin
        ram_addr <= base;
        cnt      <= len;
      end else if (issue) begin
        ram_addr <= ram_addr + 1'b1;
        cnt      <= cnt - ONE;
      end
      inflight      <= issue;
      inflight_last <= last_issue;
      done          <= (start_ok && len == '0) || (state == DRAIN && pop && dout_last);
    end
  end

  // The last flag travels with the data so the FIFO head always knows it
  jtframe_rdstream_fifo #(.w(dw + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (inflight),
    .din   ({inflight_last, ram_q}),
    .rd    (dout_ready),
    .dout  (fifo_q),
    .vld   (dout_valid),
    .cnt   (fifo_cnt)
  );

  assign dout      = fifo_q[dw-1:0];
  assign dout_last = dout_valid & fifo_q[dw];

endmodule

// File: tb/tb_jtframe_dual_ram_rdstream.sv
// Bench for the RAM read streamer with a 16-word RAM preloaded as mem[i]=0x10+i.
module tb_jtframe_dual_ram_rdstream;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] dout;
  logic          dout_valid, dout_ready, dout_last;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];

  jtframe_dual_ram_rdstream #(.dw(DW), .aw(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base       (base),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_q      (ram_q),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the dual-port RAM read port
  always @(posedge clk) ram_q <= mem[ram_addr];

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    bit         rnd;
    bit         poke;
    logic [7:0] first;
    logic [7:0] lastw;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    logic [7:0] q[$];
    logic [7:0] held, fw, lw;
    logic       held_last;
    bit         stalled, done_exp, fin;
    int         first_valid, nwords, done_idx;
    stalled = 0; fin = 0; first_valid = -1; nwords = 0; done_idx = -1;
    held = '0; held_last = 1'b0; fw = '0; lw = '0;
    for (int i = 0; i < int'(v.len); i++) q.push_back(mem[(int'(v.base) + i) % 16]);
    @(negedge clk);
    start = 1'b1; base = v.base; len = v.len; dout_ready = 1'b1;
    done_exp = (v.len == 5'd0);
    for (int idx = 0; idx < 100 && !fin; idx++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.poke && idx == 3) begin
        start = 1'b1; base = 4'd0; len = 5'd1;
      end
      dout_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("done", 32'(done), 32'(done_exp));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      if (done_exp) begin
        chk("ram_addr_end", 32'(ram_addr), 32'((int'(v.base) + int'(v.len)) % 16));
        fin = 1; done_idx = idx;
      end
      done_exp = 0;
      if (stalled) begin
        chk("stall_valid", 32'(dout_valid), 32'd1);
        chk("stall_dout", 32'(dout), 32'(held));
        chk("stall_last", 32'(dout_last), 32'(held_last));
      end
      stalled = 0;
      if (dout_valid && first_valid < 0) first_valid = idx;
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) begin
          chk("extra_word", 32'(dout), 32'hFFFF_FFFF);
        end else begin
          chk("dout", 32'(dout), 32'(q[0]));
          chk("dout_last", 32'(dout_last), 32'(q.size() == 1));
          if (nwords == 0) fw = dout;
          lw = dout;
          nwords++;
          void'(q.pop_front());
          if (q.size() == 0) done_exp = 1;
        end
      end else if (dout_valid) begin
        stalled = 1; held = dout; held_last = dout_last;
      end
    end
    if (!fin) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    #1;
    chk("done_once", 32'(done), 32'd0);
    chk("word_count", 32'(nwords), 32'(v.len));
    if (v.len != 5'd0) begin
      chk("first_word", 32'(fw), 32'(v.first));
      chk("last_word", 32'(lw), 32'(v.lastw));
      if (!v.rnd) begin
        chk("latency", 32'(first_valid), 32'd2);
        chk("throughput", 32'(done_idx), 32'(int'(v.len) + 2));
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_last"}, 32'(dout_last), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    vecs[0] = '{base: 4'd2,  len: 5'd3,  rnd: 0, poke: 0, first: 8'h12, lastw: 8'h14};
    vecs[1] = '{base: 4'd14, len: 5'd4,  rnd: 0, poke: 0, first: 8'h1E, lastw: 8'h11};
    vecs[2] = '{base: 4'd0,  len: 5'd16, rnd: 0, poke: 0, first: 8'h10, lastw: 8'h1F};
    vecs[3] = '{base: 4'd5,  len: 5'd5,  rnd: 1, poke: 0, first: 8'h15, lastw: 8'h19};
    vecs[4] = '{base: 4'd0,  len: 5'd0,  rnd: 0, poke: 0, first: 8'h00, lastw: 8'h00};
    vecs[5] = '{base: 4'd9,  len: 5'd1,  rnd: 0, poke: 0, first: 8'h19, lastw: 8'h19};
    vecs[6] = '{base: 4'd15, len: 5'd16, rnd: 1, poke: 0, first: 8'h1F, lastw: 8'h1E};
    vecs[7] = '{base: 4'd3,  len: 5'd6,  rnd: 0, poke: 1, first: 8'h13, lastw: 8'h18};
    vecs[8] = '{base: 4'd7,  len: 5'd10, rnd: 1, poke: 0, first: 8'h17, lastw: 8'h10};

    rst_n = 1'b0; start = 1'b0; base = '0; len = '0; dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) run_burst(vecs[k]);

    // Reset after two words of an 8-word burst, then a clean burst
    @(negedge clk);
    start = 1'b1; base = 4'd0; len = 5'd8; dout_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_w0", 32'(dout), 32'h10);
    @(negedge clk); #1;
    chk("rst_w1", 32'(dout), 32'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("midrst_hold_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_valid", 32'(dout_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    run_burst('{base: 4'd3, len: 5'd4, rnd: 0, poke: 0, first: 8'h13, lastw: 8'h16});

    // Random bursts against the queue model
    for (int r = 0; r < 6; r++) begin
      vec_t rv;
      rv.base  = 4'($urandom_range(0, 15));
      rv.len   = 5'($urandom_range(1, 16));
      rv.rnd   = 1;
      rv.poke  = 0;
      rv.first = mem[rv.base];
      rv.lastw = mem[(int'(rv.base) + int'(rv.len) - 1) % 16];
      run_burst(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
